// File: rtl/raster_zfetch.sv
// Z-buffer read front end: issues stored-Z reads for raster pixels and
// re-pairs returned depth with each pixel, emitting them in input order.
module raster_zfetch #(
   parameter int ADDR_W = 19,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [17:0]       in_z,
   input  logic [15:0]       in_color,
   input  logic              in_raster,
   input  logic              in_clear,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_read,
   input  logic              rd_waitrequest,
   input  logic [17:0]       rd_readdata,
   input  logic              rd_readdatavalid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [17:0]       out_pixelZ,
   output logic [17:0]       out_currZ,
   output logic [15:0]       out_color,
   output logic              out_rasterPixel,
   output logic              out_clearPixel,
   output logic              err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] a_addr_q [DEPTH];
   logic [17:0]       a_z_q    [DEPTH];
   logic [15:0]       a_col_q  [DEPTH];
   logic [DEPTH-1:0]  a_rast_q;
   logic [DEPTH-1:0]  a_clr_q;
   logic [17:0]       r_data_q [DEPTH];

   logic [PW-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d;
   logic [PW-1:0] r_wr_q, r_wr_d, r_rd_q, r_rd_d;
   logic [CW-1:0] a_cnt_q, a_cnt_d, r_cnt_q, r_cnt_d;
   logic [CW-1:0] os_q, os_d;
   logic          rd_read_q, rd_read_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic          err_q, err_d;

   logic stall, accept, issue;
   logic ret_dec, ret_push, ret_pop;
   logic head, head_nr, pop;

   assign stall    = rd_read_q & rd_waitrequest;
   assign in_ready = !reset & (a_cnt_q < FULL) & !stall;
   assign accept   = in_valid & in_ready;
   assign issue    = rd_read_q & !rd_waitrequest;

   // Returns with nothing outstanding or no room are dropped as errors.
   assign ret_dec  = rd_readdatavalid & (os_q != '0);
   assign ret_push = ret_dec & (r_cnt_q != FULL);

   assign head    = (a_cnt_q != '0);
   assign head_nr = a_rast_q[a_rd_q];
   assign pop     = out_valid & out_ready;
   assign ret_pop = pop & head_nr;

   assign out_valid       = head & (!head_nr | (r_cnt_q != '0));
   assign out_addr        = a_addr_q[a_rd_q];
   assign out_pixelZ      = a_z_q[a_rd_q];
   assign out_color       = a_col_q[a_rd_q];
   assign out_rasterPixel = head_nr;
   assign out_clearPixel  = a_clr_q[a_rd_q];
   assign out_currZ       = head_nr ? r_data_q[r_rd_q] : '0;

   assign rd_read = rd_read_q;
   assign rd_addr = rd_addr_q;
   assign err     = err_q;

   always_comb begin
      a_wr_d    = a_wr_q;
      a_rd_d    = a_rd_q;
      r_wr_d    = r_wr_q;
      r_rd_d    = r_rd_q;
      rd_read_d = rd_read_q;
      rd_addr_d = rd_addr_q;
      if (accept)   a_wr_d = a_wr_q + PW'(1);
      if (pop)      a_rd_d = a_rd_q + PW'(1);
      if (ret_push) r_wr_d = r_wr_q + PW'(1);
      if (ret_pop)  r_rd_d = r_rd_q + PW'(1);
      a_cnt_d = a_cnt_q + CW'(accept) - CW'(pop);
      r_cnt_d = r_cnt_q + CW'(ret_push) - CW'(ret_pop);
      os_d    = os_q + CW'(issue) - CW'(ret_dec);
      err_d   = err_q | (rd_readdatavalid & !ret_push);
      if (accept & in_raster) begin
         rd_read_d = 1'b1;
         rd_addr_d = in_addr;
      end else if (!stall) begin
         rd_read_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_wr_q    <= '0;
         a_rd_q    <= '0;
         r_wr_q    <= '0;
         r_rd_q    <= '0;
         a_cnt_q   <= '0;
         r_cnt_q   <= '0;
         os_q      <= '0;
         rd_read_q <= 1'b0;
         rd_addr_q <= '0;
         err_q     <= 1'b0;
      end else begin
         a_wr_q    <= a_wr_d;
         a_rd_q    <= a_rd_d;
         r_wr_q    <= r_wr_d;
         r_rd_q    <= r_rd_d;
         a_cnt_q   <= a_cnt_d;
         r_cnt_q   <= r_cnt_d;
         os_q      <= os_d;
         rd_read_q <= rd_read_d;
         rd_addr_q <= rd_addr_d;
         err_q     <= err_d;
      end
   end

   // Payload storage needs no reset; validity lives in the counters.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_addr_q[a_wr_q] <= in_addr;
         a_z_q[a_wr_q]    <= in_z;
         a_col_q[a_wr_q]  <= in_color;
         a_rast_q[a_wr_q] <= in_raster;
         a_clr_q[a_wr_q]  <= in_clear;
      end
      if (ret_push) begin
         r_data_q[r_wr_q] <= rd_readdata;
      end
   end

endmodule

// File: tb/tb_raster_zfetch.sv
// Bench for raster_zfetch: memory responder, output recorder and
// per-scenario tasks comparing against an in-order pixel reference.
module tb_raster_zfetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [18:0] in_addr = '0;
   logic [17:0] in_z = '0;
   logic [15:0] in_color = '0;
   logic        in_raster = 1'b0;
   logic        in_clear = 1'b0;
   logic [18:0] rd_addr;
   logic        rd_read;
   logic        rd_waitrequest;
   logic [17:0] rd_readdata;
   logic        rd_readdatavalid;
   logic        out_valid;
   logic        out_ready;
   logic [18:0] out_addr;
   logic [17:0] out_pixelZ;
   logic [17:0] out_currZ;
   logic [15:0] out_color;
   logic        out_rasterPixel;
   logic        out_clearPixel;
   logic        err;

   typedef struct packed {
      logic [18:0] addr;
      logic [17:0] z;
      logic [15:0] color;
      logic        raster;
      logic        clear;
      logic [17:0] cz;
   } pix_t;

   pix_t exp_q[$];
   pix_t got_q[$];
   int   acc_cyc[$];
   int   got_cyc[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ov_cnt = 0;
   int issue_cnt = 0;
   int rdv_cnt = 0;

   int mem_lat = 1;
   int wr_stall = 0;
   bit rand_wait = 0;
   bit rand_ready = 0;
   logic [18:0] pend_a[$];
   int          pend_due[$];

   raster_zfetch #(.ADDR_W(19), .DEPTH(4)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_addr(in_addr),
      .in_z(in_z),
      .in_color(in_color),
      .in_raster(in_raster),
      .in_clear(in_clear),
      .rd_addr(rd_addr),
      .rd_read(rd_read),
      .rd_waitrequest(rd_waitrequest),
      .rd_readdata(rd_readdata),
      .rd_readdatavalid(rd_readdatavalid),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_addr(out_addr),
      .out_pixelZ(out_pixelZ),
      .out_currZ(out_currZ),
      .out_color(out_color),
      .out_rasterPixel(out_rasterPixel),
      .out_clearPixel(out_clearPixel),
      .err(err)
   );

   always #5 clk = ~clk;

   // Stored Z-buffer contents as a pure function of address.
   function automatic logic [17:0] memf(input logic [18:0] a);
      if (a == 19'h00010) return 18'h09000;
      return a[17:0] ^ 18'h2B5C3 ^ {17'h0, a[18]};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         got_q.push_back({out_addr, out_pixelZ, out_color,
                          out_rasterPixel, out_clearPixel, out_currZ});
         got_cyc.push_back(cyc);
      end
      if (!reset && out_valid) ov_cnt <= ov_cnt + 1;
      if (rd_read && !rd_waitrequest) issue_cnt <= issue_cnt + 1;
      if (rd_readdatavalid) rdv_cnt <= rdv_cnt + 1;
   end

   // Memory slave: fixed latency, in-order returns, optional stalls.
   initial begin
      logic        iss;
      logic [18:0] ia;
      rd_waitrequest   = 1'b0;
      rd_readdatavalid = 1'b0;
      rd_readdata      = '0;
      out_ready        = 1'b1;
      forever begin
         @(negedge clk);
         iss = rd_read && !rd_waitrequest;
         ia  = rd_addr;
         @(posedge clk);
         #1;
         if (iss) begin
            pend_a.push_back(ia);
            pend_due.push_back(cyc - 1 + mem_lat);
         end
         if (pend_a.size() > 0 && pend_due[0] <= cyc) begin
            rd_readdatavalid = 1'b1;
            rd_readdata      = memf(pend_a.pop_front());
            void'(pend_due.pop_front());
         end else begin
            rd_readdatavalid = 1'b0;
            rd_readdata      = 18'($urandom);
         end
         if (rd_read && wr_stall > 0) begin
            rd_waitrequest = 1'b1;
            wr_stall--;
         end else if (rand_wait) begin
            rd_waitrequest = ($urandom_range(0, 3) == 0);
         end else begin
            rd_waitrequest = 1'b0;
         end
         if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      acc_cyc.delete();
      got_cyc.delete();
   endtask

   task automatic send(input logic [18:0] a, input logic [17:0] z,
                       input logic [15:0] c, input logic r,
                       input logic cl);
      bit done;
      done      = 0;
      in_addr   = a;
      in_z      = z;
      in_color  = c;
      in_raster = r;
      in_clear  = cl;
      in_valid  = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
            exp_q.push_back({a, z, c, r, cl, r ? memf(a) : 18'h0});
            acc_cyc.push_back(cyc);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_accept addr=%h in_ready=%b required 1",
                  a, in_ready);
      end
   endtask

   task automatic wait_out(input int n, input int budget, output bit ok);
      ok = 0;
      for (int k = 0; k < budget; k++) begin
         if (got_q.size() >= n) break;
         @(posedge clk);
         #1;
      end
      if (got_q.size() >= n) ok = 1;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready got=%b exp=0", in_ready);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
      end
      checks++;
      if (rd_read !== 1'b0 || rd_addr !== 19'h0) begin
         errors++;
         $display("FAIL reset_rd got=%b/%h exp=0/0", rd_read, rd_addr);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got=%b exp=0", err);
      end
   endtask

   task automatic test_raster_single();
      bit ok;
      clear_sb();
      mem_lat = 1;
      send(19'h00010, 18'h0A000, 16'hF800, 1'b1, 1'b0);
      checks++;
      if (rd_read !== 1'b1 || rd_addr !== 19'h00010) begin
         errors++;
         $display("FAIL raster_issue got=%b/%h exp=1/00010",
                  rd_read, rd_addr);
      end
      wait_out(1, 30, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL raster_timeout got=%0d outputs exp=1",
                  got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL raster_data got=%h exp=%h", got_q[0], exp_q[0]);
         end
         checks++;
         if (got_q[0].cz !== 18'h09000 || got_q[0].z !== 18'h0A000) begin
            errors++;
            $display("FAIL raster_z got=%h/%h exp=09000/0A000",
                     got_q[0].cz, got_q[0].z);
         end
         checks++;
         if (got_cyc[0] - acc_cyc[0] !== 3) begin
            errors++;
            $display("FAIL raster_latency got=%0d exp=3",
                     got_cyc[0] - acc_cyc[0]);
         end
      end
   endtask

   task automatic test_clear_single();
      bit ok;
      int i0;
      clear_sb();
      i0 = issue_cnt;
      send(19'h00020, 18'($urandom), 16'($urandom), 1'b0, 1'b1);
      wait_out(1, 30, ok);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL clear_timeout got=%0d outputs exp=1", got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL clear_data got=%h exp=%h", got_q[0], exp_q[0]);
         end
         checks++;
         if (got_q[0].cz !== 18'h0 || got_q[0].clear !== 1'b1) begin
            errors++;
            $display("FAIL clear_flags got=%h/%b exp=0/1",
                     got_q[0].cz, got_q[0].clear);
         end
         checks++;
         if (got_cyc[0] - acc_cyc[0] !== 1) begin
            errors++;
            $display("FAIL clear_latency got=%0d exp=1",
                     got_cyc[0] - acc_cyc[0]);
         end
      end
      checks++;
      if (issue_cnt !== i0) begin
         errors++;
         $display("FAIL clear_no_read got=%0d reads exp=0", issue_cnt - i0);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_sb();
      mem_lat = 3;
      send(19'h1_2340, 18'($urandom), 16'($urandom), 1'b1, 1'b0);
      send(19'h0_0777, 18'($urandom), 16'($urandom), 1'b0, 1'b1);
      send(19'h3_0F0F, 18'($urandom), 16'($urandom), 1'b1, 1'b0);
      wait_out(3, 40, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_timeout got=%0d outputs exp=3", got_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL b2b_data[%0d] got=%h exp=%h",
                        i, got_q[i], exp_q[i]);
            end
         end
         checks++;
         if (got_cyc[0] - acc_cyc[0] !== 5) begin
            errors++;
            $display("FAIL b2b_first_latency got=%0d exp=5",
                     got_cyc[0] - acc_cyc[0]);
         end
         checks++;
         if (got_cyc[1] !== got_cyc[0] + 1 || got_cyc[2] !== got_cyc[1] + 1)
         begin
            errors++;
            $display("FAIL b2b_order_cycles got=%0d,%0d,%0d exp=consecutive",
                     got_cyc[0], got_cyc[1], got_cyc[2]);
         end
      end
   endtask

   task automatic test_waitrequest();
      bit ok;
      int i0;
      logic [18:0] a;
      clear_sb();
      mem_lat  = 1;
      a        = 19'h2_5A5A;
      i0       = issue_cnt;
      wr_stall = 4;
      send(a, 18'($urandom), 16'($urandom), 1'b1, 1'b0);
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rd_read, rd_addr, in_ready, rd_waitrequest} !==
             {1'b1, a, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wait_hold[%0d] got=%b/%h/%b exp=1/%h/0",
                     i, rd_read, rd_addr, in_ready, a);
         end
         @(posedge clk);
         #2;
      end
      wait_out(1, 30, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_timeout got=%0d outputs exp=1", got_q.size());
      end else begin
         checks++;
         if (got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL wait_data got=%h exp=%h", got_q[0], exp_q[0]);
         end
      end
      checks++;
      if (issue_cnt - i0 !== 1) begin
         errors++;
         $display("FAIL wait_single_issue got=%0d exp=1", issue_cnt - i0);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_sb();
      mem_lat   = 2;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(19'($urandom), 18'($urandom), 16'($urandom), 1'b1, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_in_ready got=%b exp=0", in_ready);
      end
      checks++;
      if (got_q.size() !== 0) begin
         errors++;
         $display("FAIL bp_no_output got=%0d exp=0", got_q.size());
      end
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++)
         send(19'($urandom), 18'($urandom), 16'($urandom), 1'b1, 1'b0);
      wait_out(6, 60, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_timeout got=%0d outputs exp=6", got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL bp_data[%0d] got=%h exp=%h",
                        i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL bp_err got=%b exp=0", err);
      end
   endtask

   task automatic test_random();
      bit ok;
      int n;
      clear_sb();
      n          = 40;
      mem_lat    = $urandom_range(1, 3);
      rand_wait  = 1;
      rand_ready = 1;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
         end
         send(19'($urandom), 18'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom));
      end
      wait_out(n, 2000, ok);
      rand_wait  = 0;
      rand_ready = 0;
      out_ready  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (!ok || got_q.size() !== n) begin
         errors++;
         $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rand_data[%0d] got=%h exp=%h",
                        i, got_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL rand_err got=%b exp=0", err);
      end
   endtask

   task automatic test_reset_flush();
      bit seen;
      int r0;
      int ov0;
      clear_sb();
      mem_lat   = 6;
      out_ready = 1'b1;
      send(19'h0_1111, 18'($urandom), 16'($urandom), 1'b1, 1'b0);
      send(19'h0_2222, 18'($urandom), 16'($urandom), 1'b1, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_sb();
      r0  = rdv_cnt;
      ov0 = ov_cnt;
      checks++;
      if (err !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_after_reset got=err %b ov %b exp=0/0",
                  err, out_valid);
      end
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (rdv_cnt > r0) begin
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL flush_stale_timeout got=0 returns exp>=1");
      end
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL flush_err got=%b exp=1", err);
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (ov_cnt !== ov0 || got_q.size() !== 0) begin
         errors++;
         $display("FAIL flush_no_output got=%0d valid cycles exp=0",
                  ov_cnt - ov0);
      end
   endtask

   initial begin
      test_reset();
      test_raster_single();
      test_clear_single();
      test_back_to_back();
      test_waitrequest();
      test_backpressure();
      test_random();
      test_reset_flush();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
